conv3x3_tile_engine: RTL and testbench

//  Computes a 4x4 "valid" 2-D convolution (correlation, no kernel flip) of a 6x6 signed 8-bit tile with a 3x3 signed 8-bit kernel.
//  All 144 products are computed on 5 external DSP multiplier lanes that are time-shared.
//  The block sits between the tile/kernel buffers and the DSP column.

---
 rtl/conv3x3_tile_engine.sv | 176 +++++++++++++++++
 tb/tb_conv3x3_tile_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_tile_engine.sv
// 3x3 valid correlation of a 6x6 signed tile producing a 4x4 result, with all
// 144 products streamed through LANES time-shared external DSP multipliers.
module conv3x3_tile_engine #(
  parameter int LANES       = 5,
  parameter int DSP_LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [7:0]  input_tile [6][6],
  input  logic signed [7:0]  kernel [3][3],
  output logic signed [15:0] c [4][4],
  output logic signed [17:0] dsp_a0 [LANES],
  output logic signed [17:0] dsp_b0 [LANES],
  input  logic signed [36:0] dsp_out [LANES],
  output logic               dsp_ce,
  output logic               done
);
  localparam int NPROD = 144;
  localparam int BEATS = (NPROD + LANES - 1) / LANES;
  localparam int DW    = $clog2(DSP_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_e;

  state_e                state_q;
  logic                  start_reg;
  logic                  start_edge;
  logic                  computing;
  logic [4:0]            mul_count;
  logic [DW-1:0]         drain_q;
  logic [1:0]            m, n;
  logic signed [7:0]     tile_q [6][6];
  logic signed [7:0]     kern_q [3][3];
  logic signed [15:0]    c_q [4][4];
  logic                  iss_v [LANES];
  logic [7:0]            iss_p [LANES];
  logic signed [17:0]    iss_a [LANES];
  logic signed [17:0]    iss_b [LANES];
  logic                  tag_v_q [DSP_LATENCY+1][LANES];
  logic [7:0]            tag_p_q [DSP_LATENCY+1][LANES];
  logic [15:0]           acc_sum [4][4];
  logic [LANES-1:0]      dsp_hi_unused;
  logic                  dbg_unused;

  function automatic logic [3:0] p_entry(input logic [7:0] p);
    return 4'(p / 8'd9);
  endfunction

  function automatic logic [1:0] p_m(input logic [7:0] p);
    return 2'((p % 8'd9) / 8'd3);
  endfunction

  function automatic logic [1:0] p_n(input logic [7:0] p);
    return 2'((p % 8'd9) % 8'd3);
  endfunction

  function automatic logic [2:0] tile_row(input logic [7:0] p);
    logic [3:0] e;
    e = p_entry(p);
    return {1'b0, e[3:2]} + {1'b0, p_m(p)};
  endfunction

  function automatic logic [2:0] tile_col(input logic [7:0] p);
    logic [3:0] e;
    e = p_entry(p);
    return {1'b0, e[1:0]} + {1'b0, p_n(p)};
  endfunction

  assign start_edge = start & ~start_reg;
  assign computing  = (state_q == COMPUTE) || (state_q == DRAIN);
  assign m          = p_m(iss_p[0]);
  assign n          = p_n(iss_p[0]);
  assign dbg_unused = ^{computing, m, n, dsp_hi_unused};
  assign c          = c_q;

  // Bit 8 marks a live lane so a valid lane never looks idle, even with zero data.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      iss_p[l] = 8'(mul_count) * 8'(LANES) + 8'(l);
      iss_v[l] = (state_q == COMPUTE) && (iss_p[l] < 8'(NPROD));
      iss_a[l] = '0;
      iss_b[l] = '0;
      if (iss_v[l]) begin
        iss_a[l] = {9'd0, 1'b1, tile_q[tile_row(iss_p[l])][tile_col(iss_p[l])]};
        iss_b[l] = {9'd0, 1'b1, kern_q[p_m(iss_p[l])][p_n(iss_p[l])]};
      end
      dsp_hi_unused[l] = ^dsp_out[l][36:16];
    end
  end

  // Lanes of one beat can target the same output, so contributions are summed first.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc_sum[i][j] = '0;
        for (int l = 0; l < LANES; l++) begin
          if (tag_v_q[DSP_LATENCY][l] &&
              p_entry(tag_p_q[DSP_LATENCY][l]) == 4'(i * 4 + j))
            acc_sum[i][j] = acc_sum[i][j] + dsp_out[l][15:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      start_reg <= 1'b0;
      mul_count <= '0;
      drain_q   <= '0;
      dsp_ce    <= 1'b0;
      done      <= 1'b0;
      for (int r = 0; r < 6; r++)
        for (int k = 0; k < 6; k++) tile_q[r][k] <= '0;
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++) kern_q[r][k] <= '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) c_q[i][j] <= '0;
      for (int l = 0; l < LANES; l++) begin
        dsp_a0[l] <= '0;
        dsp_b0[l] <= '0;
        for (int d = 0; d <= DSP_LATENCY; d++) begin
          tag_v_q[d][l] <= 1'b0;
          tag_p_q[d][l] <= '0;
        end
      end
    end else begin
      start_reg <= start;
      // Stage 0 travels with the operand register, stage DSP_LATENCY meets dsp_out.
      for (int l = 0; l < LANES; l++) begin
        dsp_a0[l]     <= iss_a[l];
        dsp_b0[l]     <= iss_b[l];
        tag_v_q[0][l] <= iss_v[l];
        tag_p_q[0][l] <= iss_p[l];
        for (int d = 1; d <= DSP_LATENCY; d++) begin
          tag_v_q[d][l] <= tag_v_q[d-1][l];
          tag_p_q[d][l] <= tag_p_q[d-1][l];
        end
      end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) c_q[i][j] <= c_q[i][j] + acc_sum[i][j];
      case (state_q)
        IDLE, DONE: begin
          if (start_edge) begin
            tile_q    <= input_tile;
            kern_q    <= kernel;
            for (int i = 0; i < 4; i++)
              for (int j = 0; j < 4; j++) c_q[i][j] <= '0;
            done      <= 1'b0;
            dsp_ce    <= 1'b1;
            mul_count <= '0;
            state_q   <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (mul_count == 5'(BEATS - 1)) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end else begin
            mul_count <= mul_count + 5'd1;
          end
        end
        DRAIN: begin
          if (drain_q == DW'(DSP_LATENCY)) begin
            state_q <= DONE;
            done    <= 1'b1;
            dsp_ce  <= 1'b0;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv3x3_tile_engine.sv
// Directed and random bench for conv3x3_tile_engine with a behavioural DSP
// column model and a queue-based scoreboard of expected outputs.
module tb_conv3x3_tile_engine;
  localparam int LANES = 5;
  localparam int DLAT  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [7:0]  input_tile [6][6];
  logic signed [7:0]  kernel [3][3];
  logic signed [15:0] c [4][4];
  logic signed [17:0] dsp_a0 [LANES];
  logic signed [17:0] dsp_b0 [LANES];
  logic signed [36:0] dsp_out [LANES];
  logic               dsp_ce;
  logic               done;

  logic [15:0]        exp_q[$];
  int                 vectors = 0;
  int                 miscompares = 0;
  int                 lane_total = 0;
  int                 bad_pairs = 0;
  logic signed [36:0] pipe [DLAT][LANES];

  conv3x3_tile_engine #(.LANES(LANES), .DSP_LATENCY(DLAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_tile(input_tile), .kernel(kernel), .c(c),
    .dsp_a0(dsp_a0), .dsp_b0(dsp_b0), .dsp_out(dsp_out),
    .dsp_ce(dsp_ce), .done(done)
  );

  // clock / DSP column model
  always #5 clk = ~clk;

  function automatic logic signed [36:0] dsp_mul(input logic signed [7:0] a,
                                                  input logic signed [7:0] b);
    logic signed [36:0] ea, eb;
    ea = 37'(a);
    eb = 37'(b);
    return ea * eb;
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (!dsp_ce) begin
        for (int d = 0; d < DLAT; d++) pipe[d][l] <= '0;
      end else begin
        pipe[0][l] <= dsp_mul(dsp_a0[l][7:0], dsp_b0[l][7:0]);
        for (int d = 1; d < DLAT; d++) pipe[d][l] <= pipe[d-1][l];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) dsp_out[l] = pipe[DLAT-1][l];
  end

  always @(negedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if ((dsp_a0[l] == 18'sd0) != (dsp_b0[l] == 18'sd0)) bad_pairs++;
      if (dsp_a0[l][8] != dsp_b0[l][8]) bad_pairs++;
      if (dsp_a0[l][17:9] != 9'd0 || dsp_b0[l][17:9] != 9'd0) bad_pairs++;
      if (dsp_a0[l][8]) lane_total++;
    end
  end

  // driver / scoreboard tasks
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic signed [7:0] tv, input logic signed [7:0] kv);
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 6; k++) input_tile[r][k] = tv;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) kernel[r][k] = kv;
  endtask

  task automatic push_ref();
    int s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int m = 0; m < 3; m++)
          for (int n = 0; n < 3; n++)
            s += int'(input_tile[i+m][j+n]) * int'(kernel[m][n]);
        exp_q.push_back(16'(s));
      end
    end
  endtask

  task automatic run_job(input int hold, input string tag);
    int cyc;
    int base;
    push_ref();
    base = lane_total;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    repeat (hold) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    while (!done && cyc < 41) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) check({tag, " ce_busy"}, 32'(dsp_ce), 32'd1);
    end
    check({tag, " done_in_time"}, 32'(done), 32'd1);
    check({tag, " ce_low"}, 32'(dsp_ce), 32'd0);
    check({tag, " lanes"}, 32'(lane_total - base), 32'd144);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s c[%0d][%0d]", tag, i, j),
              32'($unsigned(c[i][j])), 32'(exp_q.pop_front()));
  endtask

  initial begin
    set_all(8'sd0, 8'sd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("rst c[%0d][%0d]", i, j), 32'($unsigned(c[i][j])), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst ce", 32'(dsp_ce), 32'd0);
    for (int l = 0; l < LANES; l++) begin
      check($sformatf("rst a0[%0d]", l), 32'($unsigned(dsp_a0[l])), 32'd0);
      check($sformatf("rst b0[%0d]", l), 32'($unsigned(dsp_b0[l])), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    set_all(8'sd1, 8'sd1);
    run_job(4, "ones");
    repeat (5) @(negedge clk);
    check("ones done_sticky", 32'(done), 32'd1);
    check("ones c33_stable", 32'($unsigned(c[3][3])), 32'd9);

    set_all(8'sd0, 8'sd0);
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 6; k++) input_tile[r][k] = 8'(6 * r + k);
    kernel[1][1] = 8'sd1;
    run_job(1, "center");
    check("center c00", 32'($unsigned(c[0][0])), 32'd7);
    check("center c33", 32'($unsigned(c[3][3])), 32'd28);

    set_all(-8'sd128, -8'sd128);
    run_job(2, "wrap");
    check("wrap c12", 32'($unsigned(c[1][2])), 32'd16384);

    set_all(8'sd0, 8'sd5);
    run_job(3, "zero");

    set_all(8'sd3, -8'sd2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("abort c[%0d][%0d]", i, j), 32'($unsigned(c[i][j])), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_job(1, "after_abort");

    for (int r = 0; r < 1000; r++) begin
      for (int a = 0; a < 6; a++)
        for (int b = 0; b < 6; b++) input_tile[a][b] = 8'($urandom_range(0, 255));
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++) kernel[a][b] = 8'($urandom_range(0, 255));
      run_job(int'($urandom_range(1, 4)), $sformatf("rand%0d", r));
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
    end

    check("operand_pairs", 32'(bad_pairs), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
